// File: rtl/lpt3_ram_master.sv
// -----------------------------------------------------------------------------
// lpt3_ram_master
//   Initiator for the single-port LPT3 RAM (combinational read, synchronous
//   write). Takes one command at a time over a valid/ready handshake, runs the
//   RAM cycles it needs, and returns one response word over a second
//   valid/ready handshake.
//
//   Commands (cmd_op):
//     00 READ  : rsp = RAM[addr]
//     01 WRITE : RAM[addr] = data, rsp = data
//     10 FILL  : RAM[addr .. addr+len-1] = data (wrapping), rsp = data
//     11 SUM   : rsp = sum of RAM[addr .. addr+len-1] mod 2**DW (wrapping)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op/addr/data/len command fields, sampled on the accepting edge only
//   rsp_valid/rsp_ready  response handshake; rsp_data held until taken
//   busy                 high whenever not idle
//   mem_addr/write/din   RAM request side
//   mem_dout             RAM read data (combinational function of mem_addr)
//
// Every output comes straight from a register or from a decode of the state
// register; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module lpt3_ram_master #(
  parameter int data_width = 9,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [data_width-1:0] cmd_data,
  input  logic [addr_width:0]   cmd_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_data,
  output logic                  busy,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_write,
  output logic [data_width-1:0] mem_din,
  input  logic [data_width-1:0] mem_dout
);

  localparam int DW = data_width;
  localparam int AW = addr_width;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_SUM   = 2'b11;

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FILL,
    S_SUM,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_rsp_data;

  logic          w_accept;
  logic          w_len_zero;
  logic          w_last;
  logic [DW-1:0] w_acc_sum;

  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_len_zero = (cmd_len == '0);
  // The run ends on the edge that consumes the last remaining word.
  assign w_last     = (r_cnt == CNT_ONE);
  // Running sum including the word currently on mem_dout; wraps mod 2**DW.
  assign w_acc_sum  = r_acc + mem_dout;

  // The RAM address and write data are plain registers, so they simply hold
  // their last value outside the states that use them.
  assign mem_addr = r_addr;
  assign mem_din  = r_data;
  assign rsp_data = r_rsp_data;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and output decode.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    mem_write    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          case (cmd_op)
            OP_READ:  w_state_next = S_READ;
            OP_WRITE: w_state_next = S_WRITE;
            OP_FILL:  w_state_next = w_len_zero ? S_RESP : S_FILL;
            default:  w_state_next = w_len_zero ? S_RESP : S_SUM;
          endcase
        end
      end
      S_READ:  w_state_next = S_RESP;
      S_WRITE: begin
        mem_write    = 1'b1;
        w_state_next = S_RESP;
      end
      S_FILL: begin
        mem_write = 1'b1;
        if (w_last) w_state_next = S_RESP;
      end
      S_SUM: begin
        if (w_last) w_state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: command latch, run counter, accumulator and response word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= cmd_addr;
            r_data <= cmd_data;
            r_cnt  <= cmd_len;
            r_acc  <= '0;
            // Zero-length runs skip straight to the response.
            if (w_len_zero && cmd_op == OP_FILL) r_rsp_data <= cmd_data;
            if (w_len_zero && cmd_op == OP_SUM)  r_rsp_data <= '0;
          end
        end
        S_READ:  r_rsp_data <= mem_dout;
        S_WRITE: r_rsp_data <= r_data;
        S_FILL: begin
          r_addr <= r_addr + 1'b1;
          r_cnt  <= r_cnt - 1'b1;
          if (w_last) r_rsp_data <= r_data;
        end
        S_SUM: begin
          r_acc  <= w_acc_sum;
          r_addr <= r_addr + 1'b1;
          r_cnt  <= r_cnt - 1'b1;
          if (w_last) r_rsp_data <= w_acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
